// File: rtl/neopixel_receiver.sv
// NeoPixel (WS2812-style) single-wire receiver: measures high pulses on the
// synchronized line, assembles 24-bit GRB words and reports frame boundaries.
module neopixel_receiver #(
    parameter int NUM_NPX      = 17,
    parameter int BIT_THRESH   = 26,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 100,
    parameter int LATCH_CYCLES = 1500
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           neopixel_data,
    output logic [23:0]                    pixel_word,
    output logic [$clog2(NUM_NPX)-1:0]     pixel_index,
    output logic                           word_valid,
    output logic                           frame_done,
    output logic [$clog2(NUM_NPX+1)-1:0]   word_count,
    output logic                           frame_error,
    output logic                           busy
);
    localparam int IDX_W = $clog2(NUM_NPX);
    localparam int CNT_W = $clog2(NUM_NPX + 1);

    localparam logic [2:0] ST_SYNC  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [11:0]      WIDTH_MAX  = 12'hFFF;
    localparam logic [11:0]      THRESH_W   = 12'(BIT_THRESH);
    localparam logic [11:0]      MIN_HIGH_W = 12'(MIN_HIGH);
    localparam logic [11:0]      MAX_HIGH_W = 12'(MAX_HIGH);
    localparam logic [11:0]      LATCH_W    = 12'(LATCH_CYCLES);
    localparam logic [CNT_W-1:0] NUM_NPX_W  = CNT_W'(NUM_NPX);

    logic [1:0]       sync_reg;
    logic             s_prev_reg;
    logic [11:0]      width_reg, width_next;
    logic [2:0]       state_reg, state_next;
    logic [23:0]      shift_reg, shift_next;
    logic [4:0]       bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0] word_idx_reg, word_idx_next;
    logic             overflow_reg, overflow_next;
    logic [23:0]      pixel_word_reg, pixel_word_next;
    logic [IDX_W-1:0] pixel_index_reg, pixel_index_next;
    logic [CNT_W-1:0] word_count_reg, word_count_next;
    logic             word_valid_reg, word_valid_next;
    logic             frame_done_reg, frame_done_next;
    logic             frame_error_reg, frame_error_next;

    logic        s, rise, fall, level_change, latch_hit, rx_bit;
    logic [23:0] shifted;

    assign s            = sync_reg[1];
    assign rise         = s & ~s_prev_reg;
    assign fall         = ~s & s_prev_reg;
    assign level_change = s ^ s_prev_reg;
    // width_reg counts samples of the previous level, so a latch gap is only
    // recognised while that level was low (also true on the rising-edge cycle).
    assign latch_hit    = ~s_prev_reg & (width_reg >= LATCH_W);
    assign rx_bit       = (width_reg >= THRESH_W);
    assign shifted      = {shift_reg[22:0], rx_bit};

    always_comb begin
        width_next = level_change ? 12'd1 :
                     (width_reg == WIDTH_MAX) ? width_reg : width_reg + 12'd1;
    end

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        word_idx_next    = word_idx_reg;
        overflow_next    = overflow_reg;
        pixel_word_next  = pixel_word_reg;
        pixel_index_next = pixel_index_reg;
        word_count_next  = word_count_reg;
        word_valid_next  = 1'b0;
        frame_done_next  = 1'b0;
        frame_error_next = 1'b0;

        case (state_reg)
            ST_SYNC, ST_ERROR: begin
                if (latch_hit) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if ((width_reg >= MAX_HIGH_W) || (fall && (width_reg < MIN_HIGH_W))) begin
                    frame_error_next = 1'b1;
                    bit_cnt_next     = 5'd0;
                    word_idx_next    = '0;
                    overflow_next    = 1'b0;
                    state_next       = ST_ERROR;
                end else if (fall) begin
                    shift_next = shifted;
                    state_next = ST_LOW;
                    if (bit_cnt_reg == 5'd23) begin
                        bit_cnt_next = 5'd0;
                        if (word_idx_reg < NUM_NPX_W) begin
                            pixel_word_next  = shifted;
                            pixel_index_next = word_idx_reg[IDX_W-1:0];
                            word_valid_next  = 1'b1;
                            word_idx_next    = word_idx_reg + CNT_W'(1);
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end
            ST_LOW: begin
                // Latch takes priority over a coincident rising edge.
                if (latch_hit) begin
                    frame_done_next  = 1'b1;
                    word_count_next  = word_idx_reg;
                    frame_error_next = (bit_cnt_reg != 5'd0) | overflow_reg;
                    bit_cnt_next     = 5'd0;
                    word_idx_next    = '0;
                    overflow_next    = 1'b0;
                    state_next       = ST_IDLE;
                end else if (rise) begin
                    state_next = ST_HIGH;
                end
            end
            default: state_next = ST_SYNC;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg        <= 2'b00;
            s_prev_reg      <= 1'b0;
            width_reg       <= 12'd0;
            state_reg       <= ST_SYNC;
            shift_reg       <= 24'd0;
            bit_cnt_reg     <= 5'd0;
            word_idx_reg    <= '0;
            overflow_reg    <= 1'b0;
            pixel_word_reg  <= 24'd0;
            pixel_index_reg <= '0;
            word_count_reg  <= '0;
            word_valid_reg  <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            sync_reg        <= {sync_reg[0], neopixel_data};
            s_prev_reg      <= s;
            width_reg       <= width_next;
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            word_idx_reg    <= word_idx_next;
            overflow_reg    <= overflow_next;
            pixel_word_reg  <= pixel_word_next;
            pixel_index_reg <= pixel_index_next;
            word_count_reg  <= word_count_next;
            word_valid_reg  <= word_valid_next;
            frame_done_reg  <= frame_done_next;
            frame_error_reg <= frame_error_next;
        end
    end

    assign pixel_word  = pixel_word_reg;
    assign pixel_index = pixel_index_reg;
    assign word_count  = word_count_reg;
    assign word_valid  = word_valid_reg;
    assign frame_done  = frame_done_reg;
    assign frame_error = frame_error_reg;
    assign busy        = (state_reg == ST_HIGH) || (state_reg == ST_LOW);
endmodule

// File: tb/tb_neopixel_receiver.sv
// Directed/randomized bench for neopixel_receiver; expected frames are derived
// from the words and bits the bench itself puts on the wire.
module tb_neopixel_receiver;
    logic        clock = 1'b0;
    logic        reset;
    logic        neopixel_data;
    logic [23:0] pixel_word;
    logic [4:0]  pixel_index;
    logic        word_valid;
    logic        frame_done;
    logic [4:0]  word_count;
    logic        frame_error;
    logic        busy;

    neopixel_receiver dut (
        .clock         (clock),
        .reset         (reset),
        .neopixel_data (neopixel_data),
        .pixel_word    (pixel_word),
        .pixel_index   (pixel_index),
        .word_valid    (word_valid),
        .frame_done    (frame_done),
        .word_count    (word_count),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #10 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: every pulse is logged; the stimulus reads these logs.
    logic [23:0] wv_word_q[$];
    int          wv_idx_q[$];
    int          fd_cnt_q[$];
    int          fd_err_q[$];
    int          err_only = 0;
    int          last_wv_cyc = 0;
    int          last_fd_cyc = 0;
    int          last_err_cyc = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (word_valid) begin
                wv_word_q.push_back(pixel_word);
                wv_idx_q.push_back(int'(pixel_index));
                last_wv_cyc = cyc;
            end
            if (frame_done) begin
                fd_cnt_q.push_back(int'(word_count));
                fd_err_q.push_back(int'(frame_error));
                last_fd_cyc = cyc;
            end
            if (frame_error && !frame_done) begin
                err_only = err_only + 1;
                last_err_cyc = cyc;
            end
        end
    end

    logic [23:0] sent[$];
    int          extra_bits;
    int          last_fall_cyc;
    int          wv_b, fd_b, er_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        wv_b = wv_word_q.size();
        fd_b = fd_cnt_q.size();
        er_b = err_only;
        sent.delete();
        extra_bits = 0;
    endtask

    // Called at a negedge; leaves the line low at a negedge.
    task automatic pulse(input int h, input int l);
        neopixel_data = 1'b1;
        repeat (h) @(negedge clock);
        neopixel_data = 1'b0;
        last_fall_cyc = cyc;
        repeat (l) @(negedge clock);
    endtask

    // mode 0: transmitter nominal timing; mode 1: random legal timing
    task automatic send_bit(input logic b, input int mode);
        int h, l;
        if (mode == 0) begin
            h = b ? 35 : 18;
            l = b ? 30 : 40;
        end else begin
            h = b ? int'($urandom_range(40, 26)) : int'($urandom_range(25, 8));
            l = int'($urandom_range(16, 4));
        end
        pulse(h, l);
    endtask

    task automatic send_word(input logic [23:0] w, input int mode);
        for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
        sent.push_back(w);
    endtask

    task automatic gap(input int n);
        neopixel_data = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_word"},  pixel_word, 0);
        check({tag, "_index"}, pixel_index, 0);
        check({tag, "_count"}, word_count, 0);
        check({tag, "_wv"},    word_valid, 0);
        check({tag, "_fd"},    frame_done, 0);
        check({tag, "_fe"},    frame_error, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    // Reference: first min(n,17) words in order, count = that, error if a
    // partial word was left or more than 17 words arrived.
    task automatic expect_frame(input string tag);
        int nw, exp_n, got_n;
        logic exp_err;
        nw      = sent.size();
        exp_n   = (nw > 17) ? 17 : nw;
        exp_err = (extra_bits != 0) || (nw > 17);
        got_n   = wv_word_q.size() - wv_b;
        check({tag, "_nwords"}, got_n, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            if (i < got_n) begin
                check($sformatf("%s_idx%0d", tag, i),  wv_idx_q[wv_b + i], i);
                check($sformatf("%s_word%0d", tag, i), wv_word_q[wv_b + i], sent[i]);
            end
        end
        check({tag, "_nframes"}, fd_cnt_q.size() - fd_b, 1);
        if (fd_cnt_q.size() > fd_b) begin
            check({tag, "_wcount"}, fd_cnt_q[fd_b], exp_n);
            check({tag, "_ferr"},   fd_err_q[fd_b], int'(exp_err));
        end
        check({tag, "_noerr_pulse"}, err_only - er_b, 0);
        $display("frame %s: %0d words sent, %0d valid seen", tag, nw, got_n);
    endtask

    initial begin
        int t0;
        logic b;
        logic [7:0] kb;
        reset = 1'b1;
        neopixel_data = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        gap(1600);

        // Nominal 17-pixel frame at transmitter timing
        mark();
        for (int k = 0; k < 17; k++) begin
            kb = k[7:0];
            send_word({kb, 8'hA5, ~kb}, 0);
        end
        t0 = last_fall_cyc;
        gap(1600);
        expect_frame("nominal");
        check("wv_latency", last_wv_cyc - t0, 3);
        check("fd_latency_ok", int'((last_fd_cyc - t0 >= 1502) && (last_fd_cyc - t0 <= 1503)), 1);

        // Threshold boundary: 25/26 highs, then 8/99 highs
        mark();
        for (int i = 23; i >= 0; i--) begin
            b = (i % 2 == 0);
            pulse(b ? 26 : 25, 30);
        end
        sent.push_back(24'h555555);
        for (int i = 23; i >= 0; i--) begin
            b = (i % 2 == 0);
            pulse(b ? 99 : 8, 30);
        end
        sent.push_back(24'h555555);
        gap(1600);
        expect_frame("thresh");

        // Glitch mid-word
        mark();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1, 0)), 1);
        pulse(5, 4);
        check("glitch_busy", busy, 0);
        gap(1600);
        check("glitch_nwords", wv_word_q.size() - wv_b, 0);
        check("glitch_nframes", fd_cnt_q.size() - fd_b, 0);
        check("glitch_err", err_only - er_b, 1);
        mark();
        send_word(24'($urandom), 1);
        gap(1600);
        expect_frame("glitch_recover");

        // Stuck high
        mark();
        neopixel_data = 1'b1;
        t0 = cyc;
        repeat (200) @(negedge clock);
        gap(1600);
        check("stuck_err", err_only - er_b, 1);
        check("stuck_latency_ok", int'((last_err_cyc - t0 >= 102) && (last_err_cyc - t0 <= 103)), 1);
        check("stuck_nframes", fd_cnt_q.size() - fd_b, 0);
        check("stuck_nwords", wv_word_q.size() - wv_b, 0);

        // Partial word: 30 bits
        mark();
        send_word(24'($urandom), 1);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(1, 0)), 1);
        extra_bits = 6;
        gap(1600);
        expect_frame("partial");

        // Overflow: 18 pixels
        mark();
        for (int k = 0; k < 18; k++) send_word(24'($urandom), 1);
        gap(1600);
        expect_frame("overflow");

        // Reset during pixel 5 while the stream continues
        mark();
        for (int k = 0; k < 5; k++) send_word(24'($urandom), 1);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1, 0)), 1);
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        for (int i = 0; i < 2; i++) send_bit(1'($urandom_range(1, 0)), 1);
        reset = 1'b0;
        mark();
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(1, 0)), 1);
        for (int k = 0; k < 3; k++) send_word(24'($urandom), 1);
        gap(1600);
        check("postrst_nwords", wv_word_q.size() - wv_b, 0);
        check("postrst_nframes", fd_cnt_q.size() - fd_b, 0);
        check("postrst_err", err_only - er_b, 0);
        mark();
        for (int k = 0; k < 3; k++) send_word(24'($urandom), 1);
        gap(1600);
        expect_frame("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
